// File: rtl/program_counter_unit_pkg.sv
// program_counter_unit_pkg: shared state encoding and constants for the program counter unit
package program_counter_unit_pkg;
    localparam logic [1:0] S_START  = 2'd0;
    localparam logic [1:0] S_RUN    = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;
    localparam logic [1:0] S_FAULT  = 2'd3;
    localparam int PC_STEP = 2;
    localparam logic [16:0] DEFAULT_RESET_VECTOR = 17'h00000;
endpackage

// File: rtl/program_counter_unit_pc_next_calc.sv
// pc_next_calc: candidate next PC (jump target or PC + offset, wrapping) and its odd-address flag
// ports: pc, offset, jump, jump_target in; candidate, odd out
module pc_next_calc #(
    parameter int WIDTH = 17
) (
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] offset,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    output logic [WIDTH-1:0] candidate,
    output logic             odd
);
    assign candidate = jump ? jump_target : pc + offset;
    assign odd = candidate[0];
endmodule

// File: rtl/program_counter_unit.sv
// program_counter_unit: architectural PC with jump, hold, halt/resume, odd-address fault and retire counter
// ports: clock, reset (async high), offset, jump, jump_target, hold, halt, resume in;
//        pc, return_address, instr_valid, halted, fault, retired out
module program_counter_unit
    import program_counter_unit_pkg::*;
#(
    parameter int               WIDTH        = 17,
    parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(DEFAULT_RESET_VECTOR),
    parameter int               COUNT_WIDTH  = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic [WIDTH-1:0]       offset,
    input  logic                   jump,
    input  logic [WIDTH-1:0]       jump_target,
    input  logic                   hold,
    input  logic                   halt,
    input  logic                   resume,
    output logic [WIDTH-1:0]       pc,
    output logic [WIDTH-1:0]       return_address,
    output logic                   instr_valid,
    output logic                   halted,
    output logic                   fault,
    output logic [COUNT_WIDTH-1:0] retired
);
    logic [1:0]       state;
    logic [WIDTH-1:0] candidate;
    logic             odd;

    pc_next_calc #(.WIDTH(WIDTH)) next_calc (
        .pc(pc),
        .offset(offset),
        .jump(jump),
        .jump_target(jump_target),
        .candidate(candidate),
        .odd(odd)
    );

    assign return_address = pc + WIDTH'(PC_STEP);
    assign instr_valid = state == S_RUN;
    assign halted = state == S_HALTED;
    assign fault = state == S_FAULT;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pc <= RESET_VECTOR;
            state <= S_START;
            retired <= '0;
        end else begin
            case (state)
                S_START: state <= S_RUN;
                S_RUN: begin
                    if (!hold) begin
                        // an odd target is never loaded; the PC keeps the last good address
                        if (odd) begin
                            state <= S_FAULT;
                        end else begin
                            pc <= candidate;
                            retired <= retired + COUNT_WIDTH'(1);
                            if (halt) state <= S_HALTED;
                        end
                    end
                end
                S_HALTED: if (resume && !hold) state <= S_RUN;
                default: state <= S_FAULT;
            endcase
        end
    end
endmodule

// File: tb/tb_program_counter_unit.sv
module tb_program_counter_unit;
    localparam int unsigned MOD = 131072;

    typedef struct {
        int unsigned pc;
        int unsigned ra;
        bit          iv;
        bit          hl;
        bit          ft;
        int unsigned ret;
    } exp_t;

    logic        clock = 0;
    logic        reset = 1;
    logic [16:0] offset = 17'd2;
    logic        jump = 0;
    logic [16:0] jump_target = '0;
    logic        hold = 0;
    logic        halt = 0;
    logic        resume = 0;
    logic [16:0] pc;
    logic [16:0] return_address;
    logic        instr_valid;
    logic        halted;
    logic        fault;
    logic [31:0] retired;

    int checks = 0;
    int failures = 0;

    int unsigned m_pc = 0;
    int unsigned m_ret = 0;
    string       m_mode = "start";
    exp_t        q[$];

    always #5 clock = ~clock;

    program_counter_unit dut (
        .clock(clock),
        .reset(reset),
        .offset(offset),
        .jump(jump),
        .jump_target(jump_target),
        .hold(hold),
        .halt(halt),
        .resume(resume),
        .pc(pc),
        .return_address(return_address),
        .instr_valid(instr_valid),
        .halted(halted),
        .fault(fault),
        .retired(retired)
    );

    function automatic exp_t snap();
        exp_t e;
        e.pc = m_pc;
        e.ra = (m_pc + 2) % MOD;
        e.iv = (m_mode == "run");
        e.hl = (m_mode == "halted");
        e.ft = (m_mode == "fault");
        e.ret = m_ret;
        return e;
    endfunction

    task automatic model_step();
        int unsigned nxt;
        if (m_mode == "start") begin
            m_mode = "run";
        end else if (m_mode == "run") begin
            if (!hold) begin
                nxt = jump ? int'(jump_target) : (m_pc + int'(offset)) % MOD;
                if (nxt % 2 == 1) begin
                    m_mode = "fault";
                end else begin
                    m_pc = nxt;
                    m_ret = m_ret + 1;
                    if (halt) m_mode = "halted";
                end
            end
        end else if (m_mode == "halted") begin
            if (resume && !hold) m_mode = "run";
        end
    endtask

    task automatic cycle(input logic [16:0] off, input logic j, input logic [16:0] jt,
                         input logic h, input logic hl, input logic rs);
        @(negedge clock);
        offset = off;
        jump = j;
        jump_target = jt;
        hold = h;
        halt = hl;
        resume = rs;
        model_step();
        q.push_back(snap());
    endtask

    // reset pulse placed between edges; outputs must clear without waiting for a clock
    task automatic pulse_reset();
        @(negedge clock);
        offset = 17'd2;
        jump = 0;
        hold = 0;
        halt = 0;
        resume = 0;
        #2 reset = 1;
        #1;
        checks++;
        if (pc !== 17'h0 || return_address !== 17'h2 || instr_valid !== 1'b0 ||
            halted !== 1'b0 || fault !== 1'b0 || retired !== 32'h0) begin
            failures++;
            $display("FAIL reset_state: got pc=%h ra=%h iv=%b halted=%b fault=%b retired=%0d, want pc=0 ra=2 iv=0 halted=0 fault=0 retired=0",
                     pc, return_address, instr_valid, halted, fault, retired);
        end
        #1 reset = 0;
        m_pc = 0;
        m_ret = 0;
        m_mode = "start";
        model_step();
        q.push_back(snap());
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                checks++;
                if (pc !== 17'(e.pc) || return_address !== 17'(e.ra) || instr_valid !== e.iv ||
                    halted !== e.hl || fault !== e.ft || retired !== e.ret) begin
                    failures++;
                    $display("FAIL cycle_check @%0t: got pc=%h ra=%h iv=%b hl=%b ft=%b ret=%0d, want pc=%h ra=%h iv=%b hl=%b ft=%b ret=%0d",
                             $time, pc, return_address, instr_valid, halted, fault, retired,
                             e.pc, e.ra, e.iv, e.hl, e.ft, e.ret);
                end
            end
        end
    end

    initial begin : stimulus
        logic [16:0] off;
        logic [16:0] jt;
        repeat (2) @(negedge clock);
        pulse_reset();
        repeat (3) cycle(17'd2, 0, 17'h0, 0, 0, 0);
        cycle(17'd2, 1, 17'h1FFFE, 0, 0, 0);
        cycle(17'd2, 0, 17'h0, 0, 0, 0);
        cycle(17'd2, 1, 17'h00010, 0, 0, 0);
        cycle(17'h1FFF8, 0, 17'h0, 0, 0, 0);
        cycle(17'd2, 1, 17'h00100, 0, 0, 0);
        cycle(17'd2, 1, 17'h00020, 0, 0, 0);
        repeat (3) cycle(17'd2, 0, 17'h0, 1, 0, 0);
        cycle(17'd2, 0, 17'h0, 0, 0, 0);
        cycle(17'd2, 1, 17'h00040, 0, 1, 0);
        repeat (5) cycle(17'($urandom), 1'($urandom), 17'($urandom), 0, 1'($urandom), 0);
        cycle(17'd2, 0, 17'h0, 1, 0, 1);
        cycle(17'd2, 0, 17'h0, 0, 0, 1);
        cycle(17'd2, 0, 17'h0, 0, 0, 0);
        cycle(17'd2, 1, 17'h00010, 0, 0, 0);
        cycle(17'd3, 0, 17'h0, 0, 0, 0);
        repeat (3) cycle(17'd2, 0, 17'h0, 0, 0, 1);
        pulse_reset();
        cycle(17'd3, 0, 17'h0, 0, 1, 0);
        cycle(17'd2, 0, 17'h0, 0, 0, 1);
        pulse_reset();
        repeat (400) begin
            if ($urandom_range(0, 49) == 0) begin
                pulse_reset();
            end else begin
                off = ($urandom_range(0, 15) == 0) ? 17'($urandom) : (17'($urandom) & 17'h1FFFE);
                jt = ($urandom_range(0, 15) == 0) ? 17'($urandom) : (17'($urandom) & 17'h1FFFE);
                cycle(off, $urandom_range(0, 3) == 0, jt, $urandom_range(0, 4) == 0,
                      $urandom_range(0, 9) == 0, $urandom_range(0, 2) == 0);
            end
        end
        repeat (2) @(negedge clock);
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain: got %0d pending expectations, want 0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
